// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sharing of one SDRAM transaction bus between CPU (port 0) and DMA (port 1).
// Optional watchdog completion of stuck transactions under `SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
  parameter int AW      = 21,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_p,
  input  logic          sdram_reset,
  input  logic          sdram_ready,
  input  logic          p0_stb,
  input  logic          p1_stb,
  input  logic          p0_we,
  input  logic          p1_we,
  input  logic [1:0]    p0_sel,
  input  logic [1:0]    p1_sel,
  input  logic [AW:1]   p0_adr,
  input  logic [AW:1]   p1_adr,
  input  logic [15:0]   p0_out,
  input  logic [15:0]   p1_out,
  output logic [15:0]   p0_dat,
  output logic [15:0]   p1_dat,
  output logic          p0_ack,
  output logic          p1_ack,
  output logic          mem_stb,
  output logic          mem_we,
  output logic [1:0]    mem_sel,
  output logic [AW:1]   mem_adr,
  output logic [15:0]   mem_out,
  input  logic [15:0]   mem_dat,
  input  logic          mem_ack,
  output logic [1:0]    grant,
  output logic          tmo_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [1:0] grant_q, grant_d;
  logic stb_q, stb_d, we_q, we_d;
  logic [1:0] sel_q, sel_d;
  logic [AW:1] adr_q, adr_d;
  logic [15:0] out_q, out_d, dat0_q, dat0_d, dat1_q, dat1_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d;
  logic pick1, own1, own_stb, own_ack, fin, tmo_hit;
  logic [15:0] rdat;
  // last_q is the port that won the previous contest; on a tie the other one wins
  assign pick1   = p1_stb && (!p0_stb || !last_q);
  assign own1    = grant_q[1];
  assign own_stb = own1 ? p1_stb : p0_stb;
  assign own_ack = own1 ? ack1_q : ack0_q;
  assign fin     = mem_ack || tmo_hit;
  assign rdat    = mem_ack ? mem_dat : 16'hFFFF;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    out_d   = out_q;
    dat0_d  = dat0_q;
    dat1_d  = dat1_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    case (state_q)
      IDLE: if (sdram_ready && (p0_stb || p1_stb)) begin
        state_d = BUSY;
        last_d  = pick1;
        grant_d = pick1 ? 2'b10 : 2'b01;
        stb_d   = 1'b1;
        we_d    = pick1 ? p1_we : p0_we;
        sel_d   = pick1 ? p1_sel : p0_sel;
        adr_d   = pick1 ? p1_adr : p0_adr;
        out_d   = pick1 ? p1_out : p0_out;
      end
      BUSY: if (fin) begin
        state_d = DONE;
        stb_d   = 1'b0;
        dat0_d  = own1 ? dat0_q : rdat;
        dat1_d  = own1 ? rdat : dat1_q;
        ack0_d  = !own1 && p0_stb;
        ack1_d  = own1 && p1_stb;
      end
      // DONE always lasts at least one cycle so mem_stb stays low for two cycles between transactions
      DONE: if (!(own_ack && own_stb)) begin
        state_d = IDLE;
        grant_d = 2'b00;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      adr_q   <= '0;
      out_q   <= '0;
      dat0_q  <= '0;
      dat1_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      out_q   <= out_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end
`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic tmo_q;
  assign tmo_hit = state_q == BUSY && !mem_ack && cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == BUSY) ? cnt_q + 1'b1 : '0;
      tmo_q <= tmo_q || tmo_hit;
    end
  end
  assign tmo_err = tmo_q;
`else
  // without the watchdog a transaction can only finish on mem_ack
  assign tmo_hit = TIMEOUT < 0;
  assign tmo_err = 1'b0;
`endif
  assign p0_dat  = dat0_q;
  assign p1_dat  = dat1_q;
  assign p0_ack  = ack0_q;
  assign p1_ack  = ack1_q;
  assign mem_stb = stb_q;
  assign mem_we  = we_q;
  assign mem_sel = sel_q;
  assign mem_adr = adr_q;
  assign mem_out = out_q;
  assign grant   = grant_q;
endmodule
